vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Parametrised single-clock video RAM shared by one CPU bus port and VID_CH video fetch channels (e.g. character, attribute, cursor).
- One memory access per cycle. Video channels are served round-robin with default priority over the CPU; the CPU sees WAIT until its access completes.
- Sits between the CPU bus decoder (CS) and the text/tile video generator. Successor to the fixed 2K×8 char RAM, generalised in width, depth, channel count and wait states.

Parameters:
- DATA_W, 8, memory word width
- ADDR_W, 11, address width; depth = 2^ADDR_W
- VID_CH, 2, number of video read channels (1..8)
- WAIT_STATES, 0, extra CPU cycles inserted before the access becomes eligible
- CPU_BOOST, 4, CPU wins arbitration after this many consecutive eligible-but-blocked cycles; 0 = video always wins
- CLEAR_VALUE, 8'h20, fill word for the optional clear (low DATA_W bits used)

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  synchronous active-low reset
- CS  in  1  CPU select, level, held until WAIT low
- WR  in  1  1 = write, 0 = read; valid with CS
- A  in  ADDR_W  CPU address
- DIN  in  DATA_W  CPU write data
- DOUT  out  DATA_W  CPU read data (write data on writes), registered
- WAIT  out  1  CPU stall, combinational
- VID_REQ  in  VID_CH  per-channel read request
- VID_A  in  VID_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W]
- VID_GNT  out  VID_CH  combinational grant, one-hot or zero
- VID_VALID  out  VID_CH  registered; high one cycle after a granted transfer
- VID_D  out  VID_CH*DATA_W  per-channel read data, held until the channel's next transfer

Behaviour:
- Reset (RESET_N low at an edge): DOUT = all ones; VID_D = 0; VID_VALID = 0; CPU FSM = IDLE; stall counter = 0; RR pointer = VID_CH-1, so channel 0 is searched first. While RESET_N is low: WAIT = CS, VID_GNT = 0, no memory writes. Memory contents are not reset.
- CPU FSM states:
  - IDLE: CS high → eligible only if WAIT_STATES == 0. If it accesses, go to DONE; otherwise go to PEND with cnt = 1, saturating at WAIT_STATES.
  - PEND: eligible when cnt == WAIT_STATES. CS low → IDLE, access aborted, no write.
  - DONE: CS low → IDLE, cnt = 0.
- WAIT = CS and state != DONE.
- CPU access at an edge: write does mem[A] ← DIN and DOUT ← DIN; read does DOUT ← mem[A]. WAIT falls in the next cycle.
- Minimum CPU latency is WAIT_STATES+1 WAIT cycles.
- Arbitration per cycle: if any VID_REQ is high and the boost condition is false, grant the first requesting channel after the RR pointer (modulo VID_CH). The pointer updates to the granted channel only on video grants.
- Boost: stall counter increments each cycle the CPU is eligible but a video channel is granted, and clears on a CPU access or in IDLE. At counter == CPU_BOOST (CPU_BOOST > 0), the CPU wins and all VID_GNT are 0.
- Video transfer (VID_REQ[i] and VID_GNT[i] at an edge): VID_D[i] ← mem[VID_A[i]]; VID_VALID[i] = 1 next cycle. VID_REQ may stay high for back-to-back reads; one read per grant.
- Same-address collision: a video read in the cycle after a CPU write to that address returns the new data. No CPU write and video read share a cycle.
- Reset asserted mid-access: state returns to IDLE, a pending write is dropped, VID_VALID clears.

Optional Feature:
- Macro VRAM_CLEAR_EN.
- Defined: after RESET_N rises, a CLEAR state writes CLEAR_VALUE to addresses 0..2^ADDR_W-1, one per cycle.
  - During CLEAR: WAIT = CS, VID_GNT = 0, VID_VALID = 0.
  - Normal operation starts in cycle 2^ADDR_W after release.
  - Reset during CLEAR restarts the sweep from 0.
- Undefined: no CLEAR state; memory is uninitialised and the block is ready in the first cycle after release.

Test Plan:
- Defaults, no video: CPU write 8'hA5 to 11'h123 → WAIT high exactly 1 cycle, DOUT = 8'hA5. Read of 11'h123 → 1 WAIT cycle, DOUT = 8'hA5.
- WAIT_STATES = 2, CS held, no video: WAIT high 3 cycles. CS dropped after 1 cycle → no write occurs (readback shows old value).
- VID_REQ = 2'b11 held 4 cycles → grants alternate ch0, ch1, ch0, ch1. Each VID_VALID comes 1 cycle after its grant with the correct VID_D.
- Both video channels requesting continuously plus CPU read, CPU_BOOST = 4 → CPU blocked exactly 4 eligible cycles, then granted. WAIT falls on the 6th cycle after CS.
- RESET_N low for 1 cycle mid-PEND with WR = 1 → DOUT = 8'hFF, target word unchanged, FSM IDLE, WAIT = CS during reset.
- VRAM_CLEAR_EN, ADDR_W = 4 → 16 cycles of WAIT with CS high, then reads of 0..15 all return 8'h20.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shared video RAM: one CPU port plus VID_CH round-robin video read channels.
// Define VRAM_CLEAR_EN to fill the RAM with CLEAR_VALUE after every reset.
module vram_arbiter #(
  parameter int          DATA_W      = 8,
  parameter int          ADDR_W      = 11,
  parameter int          VID_CH      = 2,
  parameter int          WAIT_STATES = 0,
  parameter int          CPU_BOOST   = 4,
  parameter logic [63:0] CLEAR_VALUE = 64'h20
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       CS,
  input  logic                       WR,
  input  logic [ADDR_W-1:0]          A,
  input  logic [DATA_W-1:0]          DIN,
  output logic [DATA_W-1:0]          DOUT,
  output logic                       WAIT,
  input  logic [VID_CH-1:0]          VID_REQ,
  input  logic [VID_CH*ADDR_W-1:0]   VID_A,
  output logic [VID_CH-1:0]          VID_GNT,
  output logic [VID_CH-1:0]          VID_VALID,
  output logic [VID_CH*DATA_W-1:0]   VID_D
);

  localparam int CW = $clog2(WAIT_STATES + 2);
  localparam int SW = $clog2(CPU_BOOST + 2);
  localparam int PW = (VID_CH > 1) ? $clog2(VID_CH) : 1;
  localparam logic [CW-1:0] WS    = CW'(WAIT_STATES);
  localparam logic [SW-1:0] BOOST = SW'(CPU_BOOST);
  localparam logic [CW-1:0] CNT1  = CW'(WAIT_STATES != 0);

`ifdef VRAM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, PEND, DONE, CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR;
  logic [ADDR_W-1:0] clr_a;
`else
  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [SW-1:0] stall, stall_nx;
  logic [PW-1:0] ptr, gnt_idx;
  logic [VID_CH-1:0] gnt;
  logic cpu_elig, cpu_go, boost, arb_en, found;
  logic mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign VID_GNT = gnt;
  assign WAIT    = CS && (!RESET_N || state != DONE);

  always_comb begin
    cpu_elig = CS && RESET_N &&
               ((state == IDLE && WAIT_STATES == 0) ||
                (state == PEND && cnt == WS));
    boost = (CPU_BOOST > 0) && (stall == BOOST) && cpu_elig;
    arb_en = RESET_N && !boost;
`ifdef VRAM_CLEAR_EN
    if (state == CLEAR) arb_en = 1'b0;
`endif
  end

  // first requester after the last granted channel
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 1; k <= VID_CH; k++) begin
      int idx;
      idx = (int'(ptr) + k) % VID_CH;
      if (!found && VID_REQ[idx]) begin
        found   = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    if (found && arb_en) gnt[gnt_idx] = 1'b1;
  end

  assign cpu_go = cpu_elig && !(|gnt);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_nx = stall;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (CS) begin
          if (cpu_go) begin
            state_nx = DONE;
          end else begin
            state_nx = PEND;
            cnt_nx   = CNT1;
          end
        end
      end
      PEND: begin
        if (!CS) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cpu_go) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else if (cnt != WS) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        if (!CS) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
`ifdef VRAM_CLEAR_EN
      CLEAR: begin
        if (clr_a == '1) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
    if (CPU_BOOST > 0 && cpu_elig && |gnt) stall_nx = stall + 1'b1;
    else if (cpu_go || !CS) stall_nx = '0;
  end

  always_comb begin
    mem_we = cpu_go && WR;
    mem_wa = A;
    mem_wd = DIN;
`ifdef VRAM_CLEAR_EN
    if (state == CLEAR && RESET_N) begin
      mem_we = 1'b1;
      mem_wa = clr_a;
      mem_wd = DATA_W'(CLEAR_VALUE);
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= RST_STATE;
      cnt       <= '0;
      stall     <= '0;
      ptr       <= PW'(VID_CH - 1);
      DOUT      <= '1;
      VID_VALID <= '0;
      VID_D     <= '0;
`ifdef VRAM_CLEAR_EN
      clr_a     <= '0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      stall     <= stall_nx;
      VID_VALID <= gnt;
      if (|gnt) ptr <= gnt_idx;
      if (cpu_go) DOUT <= WR ? DIN : mem[A];
      for (int i = 0; i < VID_CH; i++) begin
        if (gnt[i])
          VID_D[i*DATA_W +: DATA_W] <= mem[VID_A[i*ADDR_W +: ADDR_W]];
      end
`ifdef VRAM_CLEAR_EN
      if (state == CLEAR) clr_a <= clr_a + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: default unit plus a WAIT_STATES=2 unit.
// Honours VRAM_CLEAR_EN by waiting out the clear sweep and expecting the fill word.
module tb_vram_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int NC = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_n [2];
  logic cs [2];
  logic wr [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] din [2];
  logic [DW-1:0] dout [2];
  logic wt [2];

  logic [NC-1:0] vreq;
  logic [NC*AW-1:0] va;
  logic [NC-1:0] vgnt, vvalid, vgnt2, vvalid2;
  logic [NC*DW-1:0] vd, vd2;

  vram_arbiter u_dut (
    .CLK(CLK), .RESET_N(rst_n[0]),
    .CS(cs[0]), .WR(wr[0]), .A(a[0]), .DIN(din[0]),
    .DOUT(dout[0]), .WAIT(wt[0]),
    .VID_REQ(vreq), .VID_A(va), .VID_GNT(vgnt),
    .VID_VALID(vvalid), .VID_D(vd)
  );

  vram_arbiter #(.WAIT_STATES(2)) u_ws2 (
    .CLK(CLK), .RESET_N(rst_n[1]),
    .CS(cs[1]), .WR(wr[1]), .A(a[1]), .DIN(din[1]),
    .DOUT(dout[1]), .WAIT(wt[1]),
    .VID_REQ('0), .VID_A('0), .VID_GNT(vgnt2),
    .VID_VALID(vvalid2), .VID_D(vd2)
  );

  typedef struct {
    int ch;
    logic [DW-1:0] d;
  } vexp_t;

  int checks = 0;
  int fails = 0;
  vexp_t vq [$];
  logic [DW-1:0] cq [$];
  logic [DW-1:0] mdl [2][2**AW];
  int mptr;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(int s, bit w, logic [AW-1:0] ad,
                        logic [DW-1:0] d, int exp_w);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    @(posedge CLK); #1;
    cs[s] = 1'b1; wr[s] = w; a[s] = ad; din[s] = d;
    if (w) begin
      mdl[s][ad] = d;
      cq.push_back(d);
    end else begin
      cq.push_back(mdl[s][ad]);
    end
    while (!done && n <= 40) begin
      @(negedge CLK);
      if (wt[s]) n++;
      else done = 1'b1;
    end
    check("cpu_wait", n, exp_w);
    check("cpu_dout", dout[s], cq.pop_front());
    @(posedge CLK); #1;
    cs[s] = 1'b0;
  endtask

  task automatic vid_run(logic [NC-1:0] req, int ncyc, int nogrant_k);
    @(posedge CLK); #1;
    vreq = req;
    for (int k = 0; k < ncyc; k++) begin
      logic [NC-1:0] eg;
      int ch;
      eg = '0;
      ch = -1;
      @(negedge CLK);
      if (k != nogrant_k) begin
        for (int j = 1; j <= NC; j++) begin
          int c;
          c = (mptr + j) % NC;
          if (ch < 0 && req[c]) ch = c;
        end
      end
      if (ch >= 0) eg[ch] = 1'b1;
      check("vid_gnt", vgnt, eg);
      if (ch >= 0) begin
        vq.push_back('{ch, mdl[0][va[ch*AW +: AW]]});
        mptr = ch;
      end
    end
    @(posedge CLK); #1;
    vreq = '0;
  endtask

  task automatic clr_wait(int s);
`ifdef VRAM_CLEAR_EN
    repeat (2**AW + 2) @(posedge CLK);
    for (int i = 0; i < 2**AW; i++) begin
      if (s != 1) mdl[0][i] = 8'h20;
      if (s != 0) mdl[1][i] = 8'h20;
    end
`else
    if (s > 2) @(posedge CLK);
`endif
  endtask

  always @(negedge CLK) begin
    vexp_t e;
    if (rst_n[0] && vvalid != '0) begin
      if (vq.size() == 0) begin
        check("vid_extra", vvalid, 0);
      end else begin
        e = vq.pop_front();
        check("vid_valid", vvalid, NC'(1) << e.ch);
        check("vid_d", vd[e.ch*DW +: DW], e.d);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] ad;
    logic [DW-1:0] d;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    cs[0] = 1'b1; cs[1] = 1'b0;
    wr[0] = 1'b0; wr[1] = 1'b0;
    a[0] = '0; a[1] = '0;
    din[0] = '0; din[1] = '0;
    vreq = '1;
    va = {11'h020, 11'h010};
    mptr = NC - 1;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_dout", dout[0], 8'hFF);
    check("rst_dout2", dout[1], 8'hFF);
    check("rst_wait_cs1", wt[0], 1);
    check("rst_gnt", vgnt, 0);
    check("rst_valid", vvalid, 0);
    check("rst_vd", vd, 0);
    cs[0] = 1'b0;
    #1;
    check("rst_wait_cs0", wt[0], 0);
    @(posedge CLK); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    vreq = '0;
    clr_wait(2);

`ifdef VRAM_CLEAR_EN
    cpu_op(0, 1'b0, 11'h007, 8'h00, 1);
    cpu_op(0, 1'b0, 11'h7FF, 8'h00, 1);
`endif

    cpu_op(0, 1'b1, 11'h123, 8'hA5, 1);
    cpu_op(0, 1'b0, 11'h123, 8'h00, 1);

    for (int i = 0; i < 4; i++) begin
      ad = AW'(11'h100 + i * 37);
      d = DW'($urandom_range(0, 255));
      cpu_op(0, 1'b1, ad, d, 1);
    end
    for (int i = 0; i < 4; i++) begin
      ad = AW'(11'h100 + i * 37);
      cpu_op(0, 1'b0, ad, 8'h00, 1);
    end

    cpu_op(0, 1'b1, 11'h010, 8'h11, 1);
    cpu_op(0, 1'b1, 11'h020, 8'h22, 1);
    vid_run(2'b11, 4, -1);

    cpu_op(0, 1'b1, 11'h010, 8'h5A, 1);
    vid_run(2'b01, 1, -1);

    fork
      cpu_op(0, 1'b0, 11'h123, 8'h00, 5);
      vid_run(2'b11, 8, 4);
    join

    cpu_op(1, 1'b1, 11'h033, 8'h77, 3);
    cpu_op(1, 1'b0, 11'h033, 8'h00, 3);

    @(posedge CLK); #1;
    cs[1] = 1'b1; wr[1] = 1'b1; a[1] = 11'h033; din[1] = 8'h99;
    @(negedge CLK);
    check("abort_wait", wt[1], 1);
    @(posedge CLK); #1;
    cs[1] = 1'b0;
    cpu_op(1, 1'b0, 11'h033, 8'h00, 3);

    @(posedge CLK); #1;
    cs[1] = 1'b1; wr[1] = 1'b1; a[1] = 11'h033; din[1] = 8'hCC;
    @(negedge CLK);
    check("pend_wait", wt[1], 1);
    @(posedge CLK); #1;
    rst_n[1] = 1'b0;
    @(negedge CLK);
    check("rst_wait_pend", wt[1], 1);
    @(posedge CLK); #1;
    rst_n[1] = 1'b1;
    cs[1] = 1'b0;
    @(negedge CLK);
    check("rst_dout_pend", dout[1], 8'hFF);
    clr_wait(1);
    cpu_op(1, 1'b0, 11'h033, 8'h00, 3);

    repeat (3) @(posedge CLK);
    check("vq_drain", vq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
